// File: rtl/demux_3s_buf_if.sv
// demux_3s_buf_if: producer/consumer bundle for the 1-to-8 buffered demux
// Signals:
//   d, sel, in_valid -> word offered by the producer, channel code, offer strobe
//   in_ready         <- demux accepts the offered word this cycle
//   out_ready        -> per-channel consumer take strobes
//   o, o_valid       <- packed channel words (channel k at o[k*w +: w]) and full flags
// Modports: master = producer/consumer side, slave = demux side.
interface demux_3s_buf_if #(
    parameter int w = 4
);
    logic [w-1:0]   d;
    logic [2:0]     sel;
    logic           in_valid;
    logic           in_ready;
    logic [7:0]     out_ready;
    logic [8*w-1:0] o;
    logic [7:0]     o_valid;

    modport master (
        output d, sel, in_valid, out_ready,
        input  in_ready, o, o_valid
    );

    modport slave (
        input  d, sel, in_valid, out_ready,
        output in_ready, o, o_valid
    );
endinterface

// File: rtl/demux_3s_buf.sv
// demux_3s_buf: registered 1-to-8 demux with a one-entry holding buffer per channel
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; clears every channel word and flag
//   bus  demux_3s_buf_if.slave: d/sel/in_valid/in_ready input handshake,
//        out_ready/o/o_valid per-channel output handshake
// Parameter w: word width in bits.
module demux_3s_buf #(
    parameter int w = 4
) (
    input  logic           clk,
    input  logic           rst,
    demux_3s_buf_if.slave  bus
);
    logic [7:0]     full_q, full_n, acc, drn;
    logic [8*w-1:0] data_q, data_n;

    // in_ready looks only at the addressed channel, so full channels elsewhere never stall the input
    assign bus.in_ready = !full_q[bus.sel] || bus.out_ready[bus.sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_n;
            data_q <= data_n;
        end
    end

    // A fill wins over a drain on the same channel, giving bubble-free streaming;
    // a drain alone clears only the flag and leaves the stale word in place.
    always_comb begin
        acc    = (bus.in_valid && bus.in_ready) ? (8'b1 << bus.sel) : 8'b0;
        drn    = full_q & bus.out_ready;
        full_n = (full_q & ~drn) | acc;
        data_n = data_q;
        for (int k = 0; k < 8; k++)
            data_n[k*w +: w] = acc[k] ? bus.d : data_q[k*w +: w];
    end

    always_comb begin
        bus.o       = data_q;
        bus.o_valid = full_q;
    end
endmodule

// File: tb/tb_demux_3s_buf.sv
// tb_demux_3s_buf: directed plus randomized checks of demux_3s_buf against a channel-array model
module tb_demux_3s_buf;
    localparam int w = 4;

    logic clk = 0;
    logic rst = 1;
    int   checks = 0;
    int   errors = 0;

    logic [w-1:0] md [8];
    logic         mv [8];

    demux_3s_buf_if #(.w(w)) bus ();
    demux_3s_buf #(.w(w)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8*w-1:0] exp_o();
        logic [8*w-1:0] r;
        for (int k = 0; k < 8; k++) r[k*w +: w] = md[k];
        return r;
    endfunction

    function automatic logic [7:0] exp_v();
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = mv[k];
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 8; k++) begin
            md[k] = '0;
            mv[k] = 1'b0;
        end
    endtask

    // One clock: drive at negedge, check in_ready, advance model at posedge, check outputs.
    task automatic step(input logic [w-1:0] d, input logic [2:0] sel, input logic iv,
                        input logic [7:0] ordy, output logic rdy);
        logic acc;
        @(negedge clk);
        bus.d = d;
        bus.sel = sel;
        bus.in_valid = iv;
        bus.out_ready = ordy;
        #1;
        rdy = !mv[sel] || ordy[sel];
        chk("in_ready", {63'b0, bus.in_ready}, {63'b0, rdy});
        @(posedge clk);
        acc = iv && rdy;
        for (int k = 0; k < 8; k++) if (ordy[k]) mv[k] = 1'b0;
        if (acc) begin
            mv[sel] = 1'b1;
            md[sel] = d;
        end
        #1;
        chk("o_valid", {56'b0, bus.o_valid}, {56'b0, exp_v()});
        chk("o", {32'b0, bus.o}, {32'b0, exp_o()});
    endtask

    initial begin
        logic r;
        logic [w-1:0] rd;
        logic [2:0]   rs;
        logic         riv;
        bus.d = '0;
        bus.sel = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = '0;
        model_clear();
        #2;
        chk("rst_o", {32'b0, bus.o}, 64'h0);
        chk("rst_v", {56'b0, bus.o_valid}, 64'h0);
        @(negedge clk);
        rst = 0;

        // single route
        step(4'hA, 3'd3, 1'b1, 8'h00, r);
        chk("route_v", {56'b0, bus.o_valid}, 64'h08);
        chk("route_o", {32'b0, bus.o}, 64'h0000A000);

        // backpressure then release
        step(4'h5, 3'd3, 1'b1, 8'h00, r);
        chk("bp_rdy", {63'b0, r}, 64'h0);
        chk("bp_hold", {60'b0, bus.o[15:12]}, 64'hA);
        step(4'h5, 3'd3, 1'b1, 8'h08, r);
        chk("bp_rel_rdy", {63'b0, r}, 64'h1);
        chk("bp_rel_o", {60'b0, bus.o[15:12]}, 64'h5);
        chk("bp_rel_v", {63'b0, bus.o_valid[3]}, 64'h1);

        // independence from a stalled channel
        step(4'h7, 3'd6, 1'b1, 8'h00, r);
        chk("ind_rdy", {63'b0, r}, 64'h1);
        chk("ind_v", {56'b0, bus.o_valid}, 64'h48);
        chk("ind_o", {60'b0, bus.o[27:24]}, 64'h7);

        // asynchronous reset mid-cycle with channels full
        #2;
        rst = 1;
        #1;
        chk("arst_o", {32'b0, bus.o}, 64'h0);
        chk("arst_v", {56'b0, bus.o_valid}, 64'h0);
        model_clear();
        bus.in_valid = 1'b0;
        bus.out_ready = '0;
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 8; k++) begin
            bus.sel = 3'(k);
            #1;
            chk("arst_rdy", {63'b0, bus.in_ready}, 64'h1);
        end

        // fill all, drain all
        for (int k = 0; k < 8; k++) step(4'(k + 1), 3'(k), 1'b1, 8'h00, r);
        chk("fill_v", {56'b0, bus.o_valid}, 64'hFF);
        chk("fill_o", {32'b0, bus.o}, 64'h87654321);
        step(4'h0, 3'd0, 1'b0, 8'hFF, r);
        chk("drain_v", {56'b0, bus.o_valid}, 64'h00);
        chk("drain_o", {32'b0, bus.o}, 64'h87654321);

        // streaming into channel 0
        for (int i = 0; i < 16; i++) begin
            step(4'(i), 3'd0, 1'b1, 8'h01, r);
            chk("strm_rdy", {63'b0, r}, 64'h1);
            chk("strm_o", {60'b0, bus.o[3:0]}, 64'(i));
            chk("strm_v", {63'b0, bus.o_valid[0]}, 64'h1);
        end

        // randomized traffic; a stalled offer is held stable
        rd = '0; rs = '0; riv = 1'b0; r = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!(riv && !r)) begin
                rd  = 4'($urandom);
                rs  = 3'($urandom);
                riv = ($urandom_range(3, 0) != 0);
            end
            step(rd, rs, riv, 8'($urandom & $urandom), r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
